// File: rtl/cpu_ce_gate.sv
// Consumer side of the CPU clock-enable pair: forwards p/n enables to the core,
// swallowing whole CPU clocks for memory stalls and slow-I/O wait states.
module cpu_ce_gate #(
    parameter int unsigned SLOW_WAITS = 2,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_p_in,
    input  logic             ce_n_in,
    input  logic             stall,
    input  logic             slow_io,
    input  logic             err_clr,
    output logic             ce_p_out,
    output logic             ce_n_out,
    output logic             stalled,
    output logic [CNT_W-1:0] stall_count,
    output logic             timeout,
    output logic             proto_err
);

    localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(TIMEOUT);
    localparam logic [3:0] SLOW_LD = 4'(SLOW_WAITS);

    typedef enum logic [1:0] {
        EXPECT_P,
        EXPECT_N,
        HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       wait_q, wait_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             p_q, p_d;
    logic             n_q, n_d;
    logic             timeout_q, timeout_d;
    logic             proto_q, proto_d;
    logic             blocked;
    logic             proto_set;
    logic             tmo_set;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        p_d       = 1'b0;
        n_d       = 1'b0;
        proto_set = 1'b0;
        tmo_set   = 1'b0;
        blocked   = stall | (wait_q != '0);

        if (ce_p_in && ce_n_in) begin
            // Coincident phases: drop both and resynchronise on the next p.
            proto_set = 1'b1;
            state_d   = EXPECT_P;
        end else if (ce_p_in) begin
            if (state_q == EXPECT_N) begin
                proto_set = 1'b1;
            end
            if (!blocked) begin
                p_d     = 1'b1;
                wait_d  = slow_io ? SLOW_LD : '0;
                run_d   = '0;
                state_d = EXPECT_N;
            end else begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (wait_q != '0) begin
                    wait_d = wait_q - 4'd1;
                end
                if (run_q != RUN_MAX) begin
                    run_d = run_q + RUN_W'(1);
                    if (run_d == RUN_MAX) begin
                        tmo_set = 1'b1;
                    end
                end
                state_d = HOLD;
            end
        end else if (ce_n_in) begin
            case (state_q)
                EXPECT_N: begin
                    n_d     = 1'b1;
                    state_d = EXPECT_P;
                end
                EXPECT_P: proto_set = 1'b1;
                default:  ;
            endcase
        end

        // Set events take priority over a coincident clear.
        timeout_d = tmo_set | (timeout_q & ~err_clr);
        proto_d   = proto_set | (proto_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= EXPECT_P;
            wait_q    <= '0;
            run_q     <= '0;
            cnt_q     <= '0;
            p_q       <= 1'b0;
            n_q       <= 1'b0;
            timeout_q <= 1'b0;
            proto_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            p_q       <= p_d;
            n_q       <= n_d;
            timeout_q <= timeout_d;
            proto_q   <= proto_d;
        end
    end

    assign ce_p_out    = p_q;
    assign ce_n_out    = n_q;
    assign stalled     = (state_q == HOLD);
    assign stall_count = cnt_q;
    assign timeout     = timeout_q;
    assign proto_err   = proto_q;

endmodule

// File: tb/tb_cpu_ce_gate.sv
// Directed bench for cpu_ce_gate: 16-clk p/n generator, per-cycle output scoreboard
// plus status checks at the interesting points.
module tb_cpu_ce_gate;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ce_p_in = 1'b0;
    logic       ce_n_in = 1'b0;
    logic       stall = 1'b0;
    logic       slow_io = 1'b0;
    logic       err_clr = 1'b0;
    logic       ce_p_out;
    logic       ce_n_out;
    logic       stalled;
    logic [3:0] stall_count;
    logic       timeout;
    logic       proto_err;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_ce_gate #(
        .SLOW_WAITS(2),
        .CNT_W     (4),
        .TIMEOUT   (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ce_p_in    (ce_p_in),
        .ce_n_in    (ce_n_in),
        .stall      (stall),
        .slow_io    (slow_io),
        .err_clr    (err_clr),
        .ce_p_out   (ce_p_out),
        .ce_n_out   (ce_n_out),
        .stalled    (stalled),
        .stall_count(stall_count),
        .timeout    (timeout),
        .proto_err  (proto_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One generator clock: drive the phase inputs, record what the outputs must show
    // after the edge, then pop and compare.
    task automatic step(input logic p, input logic n, input logic ep, input logic en);
        logic [1:0] e;
        @(negedge clk);
        ce_p_in = p;
        ce_n_in = n;
        exp_q.push_back({ep, en});
        @(posedge clk);
        #1;
        ce_p_in = 1'b0;
        ce_n_in = 1'b0;
        e = exp_q.pop_front();
        chk("ce_p_out", ce_p_out, e[1]);
        chk("ce_n_out", ce_n_out, e[0]);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pstep(input logic ep);
        step(1'b1, 1'b0, ep, 1'b0);
    endtask

    task automatic nstep(input logic en);
        step(1'b0, 1'b1, 1'b0, en);
    endtask

    task automatic period(input logic ep, input logic en);
        pstep(ep);
        idle(7);
        nstep(en);
        idle(7);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ce_p"}, ce_p_out, 1'b0);
        chk({tag, "_ce_n"}, ce_n_out, 1'b0);
        chk({tag, "_stalled"}, stalled, 1'b0);
        chk({tag, "_count"}, stall_count, 4'd0);
        chk({tag, "_timeout"}, timeout, 1'b0);
        chk({tag, "_proto"}, proto_err, 1'b0);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        stall   = 1'b0;
        slow_io = 1'b0;
        err_clr = 1'b0;
        reset   = 1'b1;
        #1;
        check_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: free running, nothing blocked
        reset_dut();
        repeat (3) period(1'b1, 1'b1);
        chk("t1_stalled", stalled, 1'b0);
        chk("t1_count", stall_count, 4'd0);
        chk("t1_proto", proto_err, 1'b0);

        // 2: stall over t=15..17
        reset_dut();
        pstep(1'b1); idle(7); nstep(1'b1); idle(6);
        stall = 1'b1;
        idle(1);
        pstep(1'b0);
        chk("t2_stalled_hold", stalled, 1'b1);
        idle(1);
        stall = 1'b0;
        idle(6);
        nstep(1'b0);
        chk("t2_proto_after_drop", proto_err, 1'b0);
        idle(7);
        pstep(1'b1);
        chk("t2_count", stall_count, 4'd1);
        chk("t2_stalled_rel", stalled, 1'b0);
        nstep(1'b1); idle(7);

        // 3: stall rises after an issued p; pending n still goes out
        reset_dut();
        pstep(1'b1); idle(2);
        stall = 1'b1;
        idle(5);
        nstep(1'b1); idle(7);
        pstep(1'b0);
        chk("t3_count", stall_count, 4'd1);
        chk("t3_stalled", stalled, 1'b1);
        stall = 1'b0;
        idle(7); nstep(1'b0); idle(7);
        period(1'b1, 1'b1);

        // 4: slow I/O inserts two wait clocks
        reset_dut();
        slow_io = 1'b1;
        pstep(1'b1);
        slow_io = 1'b0;
        idle(7); nstep(1'b1); idle(7);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
        pstep(1'b1);
        chk("t4_count", stall_count, 4'd2);
        nstep(1'b1); idle(7);

        // 5: timeout after four swallowed p, sticky across an issued p, cleared by err_clr
        reset_dut();
        pstep(1'b1); idle(7); nstep(1'b1); idle(1);
        stall = 1'b1;
        idle(6);
        period(1'b0, 1'b0);
        period(1'b0, 1'b0);
        pstep(1'b0);
        chk("t5_timeout_pre", timeout, 1'b0);
        idle(7); nstep(1'b0); idle(7);
        pstep(1'b0);
        chk("t5_timeout_set", timeout, 1'b1);
        chk("t5_count", stall_count, 4'd4);
        idle(7); nstep(1'b0);
        stall = 1'b0;
        idle(7);
        pstep(1'b1);
        chk("t5_timeout_sticky", timeout, 1'b1);
        idle(7); nstep(1'b1); idle(1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t5_timeout_clr", timeout, 1'b0);

        // 6a: p and n together, with a coincident clear the set still wins
        reset_dut();
        idle(5);
        err_clr = 1'b1;
        step(1'b1, 1'b1, 1'b0, 1'b0);
        err_clr = 1'b0;
        chk("t6_proto_both", proto_err, 1'b1);
        chk("t6_count_both", stall_count, 4'd0);
        chk("t6_stalled_both", stalled, 1'b0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        chk("t6_proto_clr", proto_err, 1'b0);
        period(1'b1, 1'b1);

        // n without p, and a missing n ahead of the next p
        reset_dut();
        nstep(1'b0);
        chk("nop_proto", proto_err, 1'b1);
        reset_dut();
        pstep(1'b1); idle(15);
        pstep(1'b1);
        chk("nmiss_proto", proto_err, 1'b1);
        idle(7); nstep(1'b1); idle(7);

        // 6b: reset while EXPECT_N drops the pending n
        reset_dut();
        pstep(1'b1); idle(2);
        reset = 1'b1;
        #1;
        check_zero("t6_async");
        idle(5); nstep(1'b0); idle(1);
        check_zero("t6_held");
        reset = 1'b0;
        idle(6);
        period(1'b1, 1'b1);

        // stall_count saturates at all-ones
        reset_dut();
        stall = 1'b1;
        repeat (17) period(1'b0, 1'b0);
        chk("sat_count", stall_count, 4'd15);
        chk("sat_timeout", timeout, 1'b1);
        chk("sat_stalled", stalled, 1'b1);
        stall = 1'b0;
        period(1'b1, 1'b1);
        chk("sat_count_hold", stall_count, 4'd15);
        chk("sat_stalled_rel", stalled, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
